// File: rtl/key_conditioner_pkg.sv
// Shared definitions for pushbutton conditioning: per-key FSM states, default
// timing constants and counter sizing, reusable by other key-driven state machines.
package key_conditioner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } key_state_e;

  localparam int unsigned NUM_KEYS                = 32'd2;
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 32'd500000;
  localparam int unsigned DEFAULT_HOLD_CYCLES     = 32'd50000000;

  // Bits needed for a counter that never has to exceed n-1; at least one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    if (n <= 32'd2) begin
      w = 32'd1;
    end else begin
      w = $clog2(n);
    end
    return w;
  endfunction

endpackage

// File: rtl/key_conditioner_if.sv
// Pushbutton bundle: raw active-low keys in, conditioned level and event pulses out.
interface key_conditioner_if;
  import key_conditioner_pkg::*;

  logic [NUM_KEYS-1:0] KEY;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic [NUM_KEYS-1:0] key_hold;

  modport master (
    output KEY,
    input  key_level,
    input  key_press,
    input  key_release,
    input  key_hold
  );

  modport slave (
    input  KEY,
    output key_level,
    output key_press,
    output key_release,
    output key_hold
  );

endinterface

// File: rtl/key_debounce_channel.sv
// One pushbutton: two-flop synchronizer, debounce FSM, hold timer and registered
// level/press/release/hold outputs.
module key_debounce_channel
  import key_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEFAULT_HOLD_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_hold
);

  localparam int unsigned DEB_W  = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned HOLD_W = cnt_width(HOLD_CYCLES);
  // Entry into a WAIT state is the first stable sample, so the count ends at D-2.
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 32'd2);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 32'd1);

  logic              meta_r;
  logic              sync_r;
  key_state_e        state_r;
  key_state_e        state_s;
  logic [DEB_W-1:0]  deb_cnt_r;
  logic [HOLD_W-1:0] hold_cnt_r;
  logic              hold_fired_r;
  logic              deb_done_s;
  logic              press_s;
  logic              release_s;
  logic              hold_s;
  logic              level_s;
  logic              level_r;
  logic              press_r;
  logic              release_r;
  logic              hold_r;

  assign deb_done_s = (deb_cnt_r == DEB_LAST);

  // Two-flop synchronizer; reset value 1 means released.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
    end else begin
      meta_r <= key_raw;
      sync_r <= meta_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!sync_r) begin
          state_s = ST_PRESS_WAIT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PRESS_WAIT: begin
        if (sync_r) begin
          state_s = ST_IDLE;
        end else if (deb_done_s) begin
          state_s = ST_PRESSED;
        end else begin
          state_s = ST_PRESS_WAIT;
        end
      end
      ST_PRESSED: begin
        if (sync_r) begin
          state_s = ST_RELEASE_WAIT;
        end else begin
          state_s = ST_PRESSED;
        end
      end
      ST_RELEASE_WAIT: begin
        if (!sync_r) begin
          state_s = ST_PRESSED;
        end else if (deb_done_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RELEASE_WAIT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM output decode: values the output registers take on the next edge.
  always_comb begin
    press_s   = (state_r == ST_PRESS_WAIT) && !sync_r && deb_done_s;
    release_s = (state_r == ST_RELEASE_WAIT) && sync_r && deb_done_s;
    hold_s    = ((state_r == ST_PRESSED) || (state_r == ST_RELEASE_WAIT)) &&
                (hold_cnt_r == HOLD_LAST) && !hold_fired_r;
    if (press_s) begin
      level_s = 1'b1;
    end else if (release_s) begin
      level_s = 1'b0;
    end else begin
      level_s = level_r;
    end
  end

  // Debounce counter: runs only while a WAIT state persists, cleared otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_cnt_r <= '0;
    end else if (((state_r == ST_PRESS_WAIT) && (state_s == ST_PRESS_WAIT)) ||
                 ((state_r == ST_RELEASE_WAIT) && (state_s == ST_RELEASE_WAIT))) begin
      if (!deb_done_s) begin
        deb_cnt_r <= deb_cnt_r + DEB_W'(1);
      end else begin
        deb_cnt_r <= deb_cnt_r;
      end
    end else begin
      deb_cnt_r <= '0;
    end
  end

  // Hold timer: restarts on each accepted press, survives release bounces, saturates.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt_r   <= '0;
      hold_fired_r <= 1'b0;
    end else if (press_s) begin
      hold_cnt_r   <= '0;
      hold_fired_r <= 1'b0;
    end else if ((state_r == ST_PRESSED) || (state_r == ST_RELEASE_WAIT)) begin
      if (hold_cnt_r != HOLD_LAST) begin
        hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
      end else begin
        hold_cnt_r <= hold_cnt_r;
      end
      hold_fired_r <= hold_fired_r | hold_s;
    end else begin
      hold_cnt_r   <= hold_cnt_r;
      hold_fired_r <= hold_fired_r;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_r   <= 1'b0;
      press_r   <= 1'b0;
      release_r <= 1'b0;
      hold_r    <= 1'b0;
    end else begin
      level_r   <= level_s;
      press_r   <= press_s;
      release_r <= release_s;
      hold_r    <= hold_s;
    end
  end

  assign key_level   = level_r;
  assign key_press   = press_r;
  assign key_release = release_r;
  assign key_hold    = hold_r;

endmodule

// File: rtl/key_conditioner.sv
// Two independent debounced pushbuttons with press/release/hold event pulses.
module key_conditioner
  import key_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEFAULT_HOLD_CYCLES
) (
  input  logic                 clk,
  input  logic                 reset,
  key_conditioner_if.slave     kbus
);

  // Elaboration-time parameter legality checks.
  if (DEBOUNCE_CYCLES < 32'd2) begin : g_bad_debounce
    $error("key_conditioner: DEBOUNCE_CYCLES must be at least 2");
  end
  if (HOLD_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_hold
    $error("key_conditioner: HOLD_CYCLES must exceed DEBOUNCE_CYCLES");
  end

  logic [NUM_KEYS-1:0] level_s;
  logic [NUM_KEYS-1:0] press_s;
  logic [NUM_KEYS-1:0] release_s;
  logic [NUM_KEYS-1:0] hold_s;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES)
    ) u_channel (
      .clk         (clk),
      .reset       (reset),
      .key_raw     (kbus.KEY[i]),
      .key_level   (level_s[i]),
      .key_press   (press_s[i]),
      .key_release (release_s[i]),
      .key_hold    (hold_s[i])
    );
  end

  assign kbus.key_level   = level_s;
  assign kbus.key_press   = press_s;
  assign kbus.key_release = release_s;
  assign kbus.key_hold    = hold_s;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner (DEBOUNCE_CYCLES=4, HOLD_CYCLES=16) with a
// queue of expected pulse events checked by an independent monitor.
module tb_key_conditioner;

  typedef struct {
    int         cyc;
    logic [1:0] press;
    logic [1:0] rel;
    logic [1:0] hold;
    logic [1:0] level;
  } ev_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;
  int   n;
  ev_t  sb[$];

  key_conditioner_if kif();

  key_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .kbus  (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic wait_neg(input int cnt);
    repeat (cnt) @(negedge clk);
  endtask

  task automatic expect_ev(input int at, input logic [1:0] p, input logic [1:0] r,
                           input logic [1:0] h, input logic [1:0] l);
    ev_t e;
    e.cyc = at; e.press = p; e.rel = r; e.hold = h; e.level = l;
    sb.push_back(e);
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b required %b", name, act, req);
    end
  endtask

  // Monitor: compares every observed pulse against the oldest expectation.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      while (sb.size() != 0 && sb[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_event: no pulse at cycle %0d, required press=%b release=%b hold=%b",
                 sb[0].cyc, sb[0].press, sb[0].rel, sb[0].hold);
        sb.delete(0);
      end
      if ((kif.key_press | kif.key_release | kif.key_hold) != 2'b00) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event at cycle %0d: got press=%b release=%b hold=%b, required none",
                   cyc, kif.key_press, kif.key_release, kif.key_hold);
        end else begin
          e = sb.pop_front();
          checks++;
          if (cyc != e.cyc) begin
            errors++;
            $display("FAIL event_time: got cycle %0d required cycle %0d", cyc, e.cyc);
          end
          checks++;
          if ({kif.key_press, kif.key_release, kif.key_hold, kif.key_level} !==
              {e.press, e.rel, e.hold, e.level}) begin
            errors++;
            $display("FAIL event_value at cycle %0d: got p/r/h/l=%b/%b/%b/%b required %b/%b/%b/%b",
                     cyc, kif.key_press, kif.key_release, kif.key_hold, kif.key_level,
                     e.press, e.rel, e.hold, e.level);
          end
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    kif.KEY = 2'b11;
    wait_neg(3);
    check8("reset_outputs", {kif.key_level, kif.key_press, kif.key_release, kif.key_hold}, 8'h00);
    reset = 1'b0;
    wait_neg(5);

    // Clean press/release on key 0.
    n = cyc; kif.KEY = 2'b10; expect_ev(n + 6, 2'b01, 2'b00, 2'b00, 2'b01);
    wait_neg(10);
    n = cyc; kif.KEY = 2'b11; expect_ev(n + 6, 2'b00, 2'b01, 2'b00, 2'b00);
    wait_neg(12);

    // Bounce never reaches the debounce length.
    kif.KEY = 2'b10; wait_neg(2);
    kif.KEY = 2'b11; wait_neg(1);
    kif.KEY = 2'b10; wait_neg(2);
    kif.KEY = 2'b11; wait_neg(12);
    check8("bounce_level", {6'd0, kif.key_level}, 8'h00);

    // Long press on key 1 with hold.
    n = cyc; kif.KEY = 2'b01;
    expect_ev(n + 6, 2'b10, 2'b00, 2'b00, 2'b10);
    expect_ev(n + 22, 2'b00, 2'b00, 2'b10, 2'b10);
    wait_neg(30);
    n = cyc; kif.KEY = 2'b11; expect_ev(n + 6, 2'b00, 2'b10, 2'b00, 2'b00);
    wait_neg(12);

    // Both keys on the same edge.
    n = cyc; kif.KEY = 2'b00; expect_ev(n + 6, 2'b11, 2'b00, 2'b00, 2'b11);
    wait_neg(8);
    n = cyc; kif.KEY = 2'b11; expect_ev(n + 6, 2'b00, 2'b11, 2'b00, 2'b00);
    wait_neg(12);

    // Reset while key 0 is accepted pressed; re-press after reset.
    n = cyc; kif.KEY = 2'b10; expect_ev(n + 6, 2'b01, 2'b00, 2'b00, 2'b01);
    wait_neg(9);
    check8("level_before_reset", {6'd0, kif.key_level}, 8'h01);
    reset = 1'b1;
    wait_neg(1);
    check8("outputs_in_reset_a", {kif.key_level, kif.key_press, kif.key_release, kif.key_hold}, 8'h00);
    wait_neg(2);
    check8("outputs_in_reset_b", {kif.key_level, kif.key_press, kif.key_release, kif.key_hold}, 8'h00);
    reset = 1'b0;
    n = cyc; expect_ev(n + 6, 2'b01, 2'b00, 2'b00, 2'b01);
    wait_neg(10);
    n = cyc; kif.KEY = 2'b11; expect_ev(n + 6, 2'b00, 2'b01, 2'b00, 2'b00);
    wait_neg(12);

    // Release bounce after hold on key 1: no second hold or press.
    n = cyc; kif.KEY = 2'b01;
    expect_ev(n + 6, 2'b10, 2'b00, 2'b00, 2'b10);
    expect_ev(n + 22, 2'b00, 2'b00, 2'b10, 2'b10);
    wait_neg(25);
    kif.KEY = 2'b11; wait_neg(2);
    kif.KEY = 2'b01; wait_neg(2);
    n = cyc; kif.KEY = 2'b11; expect_ev(n + 6, 2'b00, 2'b10, 2'b00, 2'b00);
    wait_neg(40);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL pending_events: got %0d outstanding, required 0", sb.size());
    end
    check8("final_level", {6'd0, kif.key_level}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000: consecutive stable clocks required to accept a level change (10 ms at 50 MHz).
REQ-002 SHALL have parameter HOLD_CYCLES, default 50000000: clocks a key must stay accepted-pressed before a hold event fires (1 s at 50 MHz).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port KEY, input, 2 bits: raw asynchronous pushbuttons, active-low (0 = pressed).
REQ-006 SHALL have port key_level, output, 2 bits: debounced state per key, active-high (1 = pressed).
REQ-007 SHALL have port key_press, output, 2 bits: one-cycle pulse per key on accepted press.
REQ-008 SHALL have port key_release, output, 2 bits: one-cycle pulse per key on accepted release.
REQ-009 SHALL have port key_hold, output, 2 bits: one-cycle pulse per key when a press has lasted HOLD_CYCLES.

Function
REQ-010 Each KEY bit SHALL pass through a two-flop synchronizer; only the second flop's output (sync level) feeds the state machine.
REQ-011 Each key SHALL run an independent FSM: IDLE (accepted released), PRESS_WAIT, PRESSED (accepted pressed), RELEASE_WAIT.
REQ-012 IDLE -> PRESS_WAIT when sync level = 0; debounce counter cleared to 0.
REQ-013 PRESS_WAIT: counter increments each cycle sync level stays 0; when it reaches DEBOUNCE_CYCLES-1 and sync level is still 0 -> PRESSED, key_level=1, key_press pulses for exactly the next cycle.
REQ-014 PRESS_WAIT with sync level = 1 (bounce) SHALL return to IDLE, clear counter, emit no pulse.
REQ-015 PRESSED -> RELEASE_WAIT when sync level = 1; RELEASE_WAIT mirrors REQ-013/014 with opposite polarity, ending in IDLE, key_level=0, one key_release pulse.
REQ-016 Latency: clean KEY edge to press/release pulse = 2 synchronizer cycles + DEBOUNCE_CYCLES cycles, exactly.
REQ-017 Hold counter SHALL clear on entry to PRESSED, increment every cycle in PRESSED and RELEASE_WAIT, and saturate; key_hold pulses once when it reaches HOLD_CYCLES-1, at most once per accepted press.
REQ-018 A bounce in RELEASE_WAIT returning to PRESSED SHALL NOT clear the hold counter or re-fire key_press.
REQ-019 key_level SHALL change only in the cycle its press/release pulse asserts; key_press and key_release SHALL never be asserted together for one key.
REQ-020 Keys SHALL be fully independent; simultaneous edges on both keys produce simultaneous pulses with identical latency.
REQ-021 Counter widths SHALL be derived from parameters (clog2); no wrap-around permitted at any parameter value.
REQ-022 Parameter legality: DEBOUNCE_CYCLES >= 2, HOLD_CYCLES > DEBOUNCE_CYCLES; simulation SHALL flag violations.

Reset
REQ-023 reset SHALL force: synchronizer flops to 1 (released), FSMs to IDLE, all counters to 0, key_level/key_press/key_release/key_hold to 0.
REQ-024 Reset asserted mid-debounce or mid-press SHALL drop any pending event; no pulse emitted on the cycle reset deasserts.
REQ-025 A key held down through reset deassertion SHALL be accepted as a new press after 2 + DEBOUNCE_CYCLES cycles.

Structure
REQ-026 FSM state encodings and the default cycle constants SHALL live in a shared package for reuse by reaction-timer state machines.
REQ-027 Per-key logic (synchronizer, FSM, both counters) SHALL be a sub-module key_debounce_channel, instantiated twice.
REQ-028 Outputs SHALL be registered; no combinational path from KEY to any output.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=16)
REQ-029 KEY[0] driven 1->0 clean -> key_press[0] single pulse exactly 6 cycles later, key_level[0]=1 from that cycle; KEY[1] outputs stay 0.
REQ-030 KEY[0] low 2 cycles, high 1, low 2, high (bounce) -> no pulses, key_level[0] stays 0.
REQ-031 KEY[1] held low 30 cycles -> one key_press[1], one key_hold[1] 16 cycles after the press pulse, nothing further; release -> key_release[1] 6 cycles after rising edge.
REQ-032 Both KEY bits fall on the same edge -> key_press = 2'b11 in one cycle.
REQ-033 reset pulsed while KEY[0] held pressed with key_level[0]=1 -> all outputs 0 during reset; key_press[0] re-fires 6 cycles after reset deasserts.
REQ-034 Release during RELEASE_WAIT bounce after key_hold fired -> no second key_hold, no second key_press.
